muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit (HI/LO) for the multi-cycle CPU. Sits directly

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_step.sv | 45 ++++
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 tb/tb_muldiv_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : muldiv_pkg
// Description : Shared operation encodings, FSM states and default width for
//               the iterative HI/LO multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  // Divide ops occupy the upper half of the encoding space.
  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  // Signed variants are MULT and DIV.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One iteration of the multiply/divide datapath on the {acc,q}
//               register pair. Multiply: shift-add, low multiplier bit in q[0],
//               product shifts right into q. Divide: restoring shift-subtract,
//               dividend shifts out of q's MSB, quotient bits enter at q[0].
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Single shift-add or restoring shift-subtract step.
  always_comb begin
    sum      = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    shifted  = {acc, q[WIDTH-1]};
    diff     = shifted - {1'b0, m};
    acc_next = sum[WIDTH:1];
    q_next   = {sum[0], q[WIDTH-1:1]};
    if (is_div) begin
      // diff[WIDTH] set means the trial subtraction borrowed: restore.
      if (!diff[WIDTH]) begin
        acc_next = diff[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative HI/LO multiply/divide unit. Operands are reduced to
//               magnitudes on start, WIDTH unsigned iterations run in CALC,
//               signs and the divide-by-zero case are resolved in FIX, and
//               HI/LO are presented with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc, q, m;
  logic [WIDTH-1:0]   acc_next, q_next;
  logic [WIDTH-1:0]   a_orig;
  logic               is_div_r, neg_res, neg_rem, div_zero;

  logic               in_div, in_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_r),
    .acc      (acc),
    .q        (q),
    .m        (m),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  // Operand magnitudes and sign flags captured when an op is launched.
  always_comb begin
    in_div    = op_is_div(op);
    in_signed = op_is_signed(op);
    a_neg     = in_signed & a[WIDTH-1];
    b_neg     = in_signed & b[WIDTH-1];
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
  end

  // Sign correction and divide-by-zero override of the raw iteration result.
  always_comb begin
    prod_fix = neg_res ? (~{acc, q} + 1'b1) : {acc, q};
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div_r) begin
      fix_lo = neg_res ? (~q + 1'b1) : q;
      fix_hi = neg_rem ? (~acc + 1'b1) : acc;
      if (div_zero) begin
        fix_lo = '1;
        fix_hi = a_orig;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Iteration datapath: operand capture on start, one step per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      a_orig   <= '0;
      is_div_r <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt      <= '0;
      acc      <= '0;
      q        <= in_div ? a_mag : b_mag;
      m        <= in_div ? b_mag : a_mag;
      a_orig   <= a;
      is_div_r <= in_div;
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= in_div && (b == '0);
    end else if (state == CALC) begin
      cnt <= cnt + CNT_W'(1);
      acc <= acc_next;
      q   <= q_next;
    end
  end

  // HI/LO: moves only when idle without start; results land entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == IDLE && !start) begin
      if (mthi) hi <= a;
      if (mtlo) lo <= a;
    end else if (state == FIX) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit: vector table of ops with
//               hand-computed HI/LO plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int passed = 0;
  int total  = 0;
  int cyc, lat, bcnt, dcnt;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[12];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Advance to the next negedge and record status seen in that cycle.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (busy) bcnt++;
    if (done) begin
      dcnt++;
      if (lat < 0) lat = cyc;
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic with_mthi);
    @(negedge clk);
    op = o; a = aa; b = bb; start = 1'b1; mthi = with_mthi;
    @(posedge clk);
    #1;
    start = 1'b0; mthi = 1'b0;
    cyc = 0; lat = -1; bcnt = 0; dcnt = 0;
  endtask

  task automatic wait_done();
    while (lat < 0 && cyc < 80) step();
  endtask

  initial begin
    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[5]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[6]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[7]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[9]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[10] = '{OP_MULT,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[11] = '{OP_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_hi", hi, '0);
    check("reset_lo", lo, '0);
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      wait_done();
      check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("vec%0d_latency", i), W'(lat), W'(LAT));
      check($sformatf("vec%0d_busy_cycles", i), W'(bcnt), W'(LAT));
      step();
    end

    // MTHI / MTLO in idle, singly and together
    @(negedge clk);
    a = 32'h1234; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_idle", hi, 32'h1234);
    a = 32'h5678; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_idle", lo, 32'h5678);
    check("mtlo_keeps_hi", hi, 32'h1234);
    a = 32'hAAAA; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_mtlo_hi", hi, 32'hAAAA);
    check("mthi_mtlo_lo", lo, 32'hAAAA);

    // start with mthi: start wins; mtlo while busy ignored; old HI/LO held
    launch(OP_MULTU, 32'd7, 32'd3, 1'b1);
    step();
    check("start_wins_mthi", hi, 32'hAAAA);
    check("busy_after_start", W'(busy), W'(1));
    step(); step();
    a = 32'hDEAD; mtlo = 1'b1;
    step();
    mtlo = 1'b0;
    check("mtlo_busy_ignored", lo, 32'hAAAA);
    check("hi_held_busy", hi, 32'hAAAA);
    wait_done();
    check("seq_mult_hi", hi, 32'h0);
    check("seq_mult_lo", lo, 32'h15);
    check("seq_mult_latency", W'(lat), W'(LAT));

    // Second start mid-operation is ignored: one done, DIVU-by-zero result
    launch(OP_DIVU, 32'd100, 32'd0, 1'b0);
    repeat (5) step();
    op = OP_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    wait_done();
    check("dz_hi", hi, 32'd100);
    check("dz_lo", lo, 32'hFFFFFFFF);
    check("dz_latency", W'(lat), W'(LAT));
    repeat (40) step();
    check("dz_single_done", W'(dcnt), W'(1));

    // Asynchronous reset during CALC aborts the op
    launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", W'(busy), '0);
    check("abort_hi", hi, '0);
    check("abort_lo", lo, '0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = -1; dcnt = 0;
    repeat (40) step();
    check("abort_no_done", W'(dcnt), '0);
    check("abort_hi_after", hi, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
